// File: rtl/neural_pkg.sv
// Shared fixed-point types and helpers for the neuron datapath (Q8.8 values,
// wide accumulation type and saturation back to Q8.8).
package neural_pkg;

  typedef logic signed [15:0] res_t;
  typedef logic signed [23:0] mac_t;

  localparam res_t Q_MAX = res_t'(16'h7fff);
  localparam res_t Q_MIN = res_t'(16'h8000);

  function automatic res_t saturate(input mac_t x);
    if (x > mac_t'(Q_MAX)) return Q_MAX;
    else if (x < mac_t'(Q_MIN)) return Q_MIN;
    else return res_t'(x[15:0]);
  endfunction

endpackage

// File: rtl/loss_accumulator.sv
// Epoch loss monitor for objective: counts samples, accumulates |diff| with
// saturation and latches the mean absolute error at the end of each epoch.
module loss_accumulator #(
  parameter int LOG_EPOCH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        add_en,
  input  logic [16:0] add_val,
  input  logic        smp_done,
  input  logic        clr,
  output logic        epoch_end,
  output logic [15:0] los_dat
);
  logic [LOG_EPOCH-1:0] cnt;
  logic [31:0]          acc;
  logic [32:0]          sum;
  logic [31:0]          mean_wide;
  logic [15:0]          mean;

  assign sum       = {1'b0, acc} + {16'b0, add_val};
  assign mean_wide = acc >> LOG_EPOCH;
  assign mean      = (|mean_wide[31:16]) ? 16'hffff : mean_wide[15:0];
  assign epoch_end = &cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      acc     <= '0;
      los_dat <= '0;
    end else begin
      if (smp_done) begin
        cnt <= cnt + LOG_EPOCH'(1);
        // The current sample's |diff| was already added while in DIF.
        if (epoch_end) los_dat <= mean;
      end
      if (clr) acc <= '0;
      else if (add_en) acc <= sum[32] ? '1 : sum[31:0];
    end
  end

endmodule

// File: rtl/objective.sv
// Error source for an associate neuron: pairs a result with its training target and
// emits the saturated, gain-scaled error. Define OBJECTIVE_LOSS_EN for the epoch MAE monitor.
module objective
  import neural_pkg::*;
#(
  parameter int SHIFT     = 0,
  parameter int LOG_EPOCH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_stb,
  input  logic [15:0] res_dat,
  output logic        res_rdy,
  input  logic        tgt_stb,
  input  logic [15:0] tgt_dat,
  output logic        tgt_rdy,
  output logic        err_stb,
  output logic [15:0] err_dat,
  input  logic        err_rdy,
  output logic        los_stb,
  output logic [15:0] los_dat,
  input  logic        los_rdy
);
  typedef enum logic [1:0] {COL, DIF, ERR, LOS} state_t;

  state_t      state, state_nx;
  logic        have_res, have_tgt;
  res_t        res_q, tgt_q, err_q;
  res_t        diff_sat;
  logic [16:0] diff_abs;
  logic        res_xfer, tgt_xfer, err_xfer, los_xfer, epoch_end;

  assign res_rdy  = (state == COL) && !have_res;
  assign tgt_rdy  = (state == COL) && !have_tgt;
  assign err_stb  = (state == ERR);
  assign err_dat  = err_q;
  assign res_xfer = res_stb && res_rdy;
  assign tgt_xfer = tgt_stb && tgt_rdy;
  assign err_xfer = err_stb && err_rdy;

  assign diff_sat = saturate(mac_t'(tgt_q) - mac_t'(res_q));
  // 17 bits so that the magnitude of -32768 is representable.
  assign diff_abs = diff_sat[15] ? (17'd0 - {1'b1, diff_sat}) : {1'b0, diff_sat};

`ifdef OBJECTIVE_LOSS_EN
  localparam bit LOSS_EN = 1'b1;

  assign los_stb  = (state == LOS);
  assign los_xfer = los_stb && los_rdy;

  loss_accumulator #(.LOG_EPOCH(LOG_EPOCH)) u_loss (
    .clk      (clk),
    .rst      (rst),
    .add_en   (state == DIF),
    .add_val  (diff_abs),
    .smp_done (err_xfer),
    .clr      (los_xfer),
    .epoch_end(epoch_end),
    .los_dat  (los_dat)
  );
`else
  localparam bit LOSS_EN = 1'b0;

  logic [18:0] unused_loss;
  assign unused_loss = {los_rdy, diff_abs, 1'(LOG_EPOCH)};
  assign los_stb     = 1'b0;
  assign los_dat     = '0;
  assign los_xfer    = 1'b0;
  assign epoch_end   = 1'b0;
`endif

  // NOTE: state_nx gets its default before the case so no path infers a latch.
  always_comb begin
    state_nx = state;
    case (state)
      COL: if (have_res && have_tgt) state_nx = DIF;
      DIF: state_nx = ERR;
      ERR: if (err_xfer) state_nx = (LOSS_EN && epoch_end) ? LOS : COL;
      LOS: if (los_xfer || !LOSS_EN) state_nx = COL;
      default: state_nx = COL;
    endcase
  end

  // NOTE: non-blocking updates so every statement here sees pre-edge values;
  // payload registers are reset too, since err_dat must read 0 out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= COL;
      have_res <= 1'b0;
      have_tgt <= 1'b0;
      res_q    <= '0;
      tgt_q    <= '0;
      err_q    <= '0;
    end else begin
      state <= state_nx;
      if (res_xfer) begin
        have_res <= 1'b1;
        res_q    <= res_t'(res_dat);
      end
      if (tgt_xfer) begin
        have_tgt <= 1'b1;
        tgt_q    <= res_t'(tgt_dat);
      end
      if (err_xfer) begin
        have_res <= 1'b0;
        have_tgt <= 1'b0;
      end
      if (state == DIF) err_q <= diff_sat >>> SHIFT;
    end
  end

endmodule

// File: doc/objective.md
Name: objective

Overview:
- Error source for an associate neuron; it is the other end of that neuron's res/err channels.
- Accepts the neuron's 16-bit inner-product result and a 16-bit training target.
- Emits the scaled, saturated error delta on the err channel, which the neuron consumes as its error input.
- Optionally accumulates a mean-absolute-error loss over an epoch for monitoring.
- Sits between a neuron and the training-data source / host.

Parameters:
SHIFT, 0, arithmetic right shift applied to (target - result) before output (learning gain).
LOG_EPOCH, 4, log2 of samples per loss epoch (used only with loss feature).

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-low reset.
res_stb  in  1  result valid.
res_dat  in  16  signed result (Q8.8).
res_rdy  out  1  result accept.
tgt_stb  in  1  target valid.
tgt_dat  in  16  signed target (Q8.8).
tgt_rdy  out  1  target accept.
err_stb  out  1  error valid.
err_dat  out  16  signed error delta.
err_rdy  in  1  error accept.
los_stb  out  1  loss valid (feature only).
los_dat  out  16  unsigned mean absolute error (feature only).
los_rdy  in  1  loss accept (feature only).

Behaviour:
- Handshakes: transfer occurs on stb & rdy in the same cycle.
  - Producer holds stb and dat stable until the transfer.
  - This block's stb outputs deassert the cycle after their transfer.
- Reset (rst low, async):
  - state = COL.
  - err_stb = 0, los_stb = 0, err_dat = 0, los_dat = 0.
  - Capture flags, sample counter and loss accumulator cleared.
  - res_rdy = tgt_rdy = 1 once reset is released.
  - Reset mid-transfer drops stb immediately; no partial transfer is completed.
- States: COL, DIF, ERR, LOS.
- COL:
  - res_rdy = !have_res, tgt_rdy = !have_tgt; result and target are captured independently in either order.
  - Simultaneous arrival in the same cycle: both are captured.
  - When both are held, go to DIF next cycle. Minimum latency from last capture to err_stb high is 2 cycles.
- DIF (1 cycle):
  - diff = 17-bit signed (tgt - res), saturated to [-32768, 32767].
  - err_dat <= saturate(diff) >>> SHIFT, arithmetic shift.
  - |diff| is added to the accumulator (feature only).
  - Go to ERR.
- ERR:
  - err_stb = 1; err_dat stable; res_rdy and tgt_rdy are low.
  - On err_stb & err_rdy: clear capture flags and increment the sample counter.
  - If the feature is on and the counter wraps (2**LOG_EPOCH - 1 → 0), go to LOS; otherwise go to COL.
- LOS:
  - los_stb = 1; los_dat = saturate_u16(acc >> LOG_EPOCH).
  - On los_stb & los_rdy: clear the accumulator and go to COL.
- Accumulator: 32 bits unsigned, saturates at all-ones; no wrap.
- Invalid state: return to COL.

Optional Feature:
OBJECTIVE_LOSS_EN
- Defined: sample counter, accumulator and LOS state are present as described.
- Undefined:
  - Counter, accumulator and LOS state are removed.
  - los_stb and los_dat are tied to 0; los_rdy is ignored.
  - ERR always returns to COL.

Decomposition:
- Shared package (neural_pkg): Q8.8 type res_t (signed 16), wide type mac_t (signed 24), Q8.8 MAX/MIN constants, saturate function.
- State enum stays local to this block.
- One natural sub-module: loss_accumulator (counter, saturating |diff| accumulator, LOS output register), instantiated only under OBJECTIVE_LOSS_EN.

Test Plan:
- Basic: res = 0x0100, tgt = 0x0300, SHIFT = 0 → err_dat = 0x0200 with err_stb high exactly 2 cycles after both are captured. Repeat with SHIFT = 2 → 0x0080.
- Saturation: tgt = 0x7FFF, res = 0x8000 → err_dat = 0x7FFF. tgt = 0x8000, res = 0x7FFF → err_dat = 0x8000.
- Ordering: tgt 5 cycles before res → tgt_rdy low after capture, res_rdy stays high until res arrives. Simultaneous res/tgt → both captured the same cycle.
- Backpressure: err_rdy low 10 cycles → err_stb held, err_dat stable, res_rdy/tgt_rdy low throughout. After release, next sample is accepted.
- Loss (feature on, LOG_EPOCH = 2): diffs +4, -4, +8, 0 → los_dat = 4 after the 4th err transfer. Accumulator is zero afterwards. With the feature off, los_stb never rises.
- Reset: assert rst low while in ERR with err_rdy low → err_stb drops asynchronously. After release, state is COL and the next sample is processed correctly.
